// File: rtl/rdma_sq_wqe_fetch_pkg.sv
// Shared constants for the SQ WQE fetch path:
// FSM encoding, WQE field positions and stat limits.
package rdma_sq_wqe_fetch_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_READ    = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_OUT     = 2'd3;

  localparam int VLD_BIT = 0;
  localparam int OPC_LSB = 4;
  localparam int OPC_W   = 4;
  localparam int LEN_LSB = 32;
  localparam int LEN_W   = 32;

  localparam logic [15:0] STAT_INV_MAX = 16'hFFFF;

endpackage

// File: rtl/rdma_db_fifo.sv
// Doorbell FIFO: synchronous, show-ahead read data,
// pushes ignored when full, pops ignored when empty.
module rdma_db_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit tells full from empty.
  assign full = (wr_ptr[PW] != rd_ptr[PW]) &&
                (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_data = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/rdma_sq_wqe_fetch.sv
// SQ WQE fetch: doorbells queue QP indices, each one triggers
// a config RAM read and, if the entry is valid, a WQE output.
module rdma_sq_wqe_fetch
  import rdma_sq_wqe_fetch_pkg::*;
#(
  parameter int CONFIG_RAM_AWIDTH = 4,
  parameter int CONFIG_RAM_DWIDTH = 512,
  parameter int DB_FIFO_DEPTH     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CONFIG_RAM_AWIDTH-1:0] s_db_qpn,
  input  logic                         s_db_valid,
  output logic                         s_db_ready,
  output logic                         tx_config_ram_ren,
  output logic [CONFIG_RAM_AWIDTH-1:0] tx_config_ram_raddr,
  input  logic [CONFIG_RAM_DWIDTH-1:0] tx_config_ram_rdata,
  output logic [CONFIG_RAM_DWIDTH-1:0] m_wqe_data,
  output logic [CONFIG_RAM_AWIDTH-1:0] m_wqe_qpn,
  output logic [3:0]                   m_wqe_opcode,
  output logic [31:0]                  m_wqe_len,
  output logic                         m_wqe_valid,
  input  logic                         m_wqe_ready,
  output logic [31:0]                  stat_wqe_cnt,
  output logic [15:0]                  stat_inv_cnt
);

  localparam int AW = CONFIG_RAM_AWIDTH;

  logic [1:0]    state;
  logic [AW-1:0] qpn_r;
  logic [AW-1:0] fifo_qpn;
  logic          fifo_full;
  logic          fifo_empty;
  logic          db_push;
  logic          fifo_pop;
  logic [15:0]   inv_cnt_q;

  // Ready is held low during reset so nothing is lost into a clearing FIFO.
  assign s_db_ready  = !fifo_full && !rst;
  assign db_push     = s_db_valid && s_db_ready;
  assign fifo_pop    = (state == ST_IDLE) && !fifo_empty;
  assign m_wqe_valid = (state == ST_OUT);
  assign stat_inv_cnt = inv_cnt_q;

  rdma_db_fifo #(
    .WIDTH (AW),
    .DEPTH (DB_FIFO_DEPTH)
  ) u_db_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (db_push),
    .push_data (s_db_qpn),
    .pop       (fifo_pop),
    .pop_data  (fifo_qpn),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= ST_IDLE;
      qpn_r               <= '0;
      tx_config_ram_ren   <= 1'b0;
      tx_config_ram_raddr <= '0;
      m_wqe_data          <= '0;
      m_wqe_qpn           <= '0;
      m_wqe_opcode        <= '0;
      m_wqe_len           <= '0;
      stat_wqe_cnt        <= '0;
      inv_cnt_q           <= '0;
    end else begin
      tx_config_ram_ren <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            qpn_r               <= fifo_qpn;
            tx_config_ram_ren   <= 1'b1;
            tx_config_ram_raddr <= fifo_qpn;
            state               <= ST_READ;
          end
        end
        ST_READ: begin
          state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (tx_config_ram_rdata[VLD_BIT]) begin
            m_wqe_data   <= tx_config_ram_rdata;
            m_wqe_qpn    <= qpn_r;
            m_wqe_opcode <= tx_config_ram_rdata[OPC_LSB +: OPC_W];
            m_wqe_len    <= tx_config_ram_rdata[LEN_LSB +: LEN_W];
            state        <= ST_OUT;
          end else begin
            if (inv_cnt_q != STAT_INV_MAX)
              inv_cnt_q <= inv_cnt_q + 16'd1;
            state <= ST_IDLE;
          end
        end
        ST_OUT: begin
          if (m_wqe_ready) begin
            stat_wqe_cnt <= stat_wqe_cnt + 32'd1;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rdma_sq_wqe_fetch.sv
// Self-checking bench for rdma_sq_wqe_fetch: vector table,
// scoreboard of expected WQEs and multi-cycle corner sequences.
module tb_rdma_sq_wqe_fetch;

  localparam int AW = 4;
  localparam int DW = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] s_db_qpn = '0;
  logic          s_db_valid = 1'b0;
  logic          s_db_ready;
  logic          ren;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata = '0;
  logic [DW-1:0] m_wqe_data;
  logic [AW-1:0] m_wqe_qpn;
  logic [3:0]    m_wqe_opcode;
  logic [31:0]   m_wqe_len;
  logic          m_wqe_valid;
  logic          m_wqe_ready = 1'b1;
  logic [31:0]   stat_wqe_cnt;
  logic [15:0]   stat_inv_cnt;

  rdma_sq_wqe_fetch #(
    .CONFIG_RAM_AWIDTH (AW),
    .CONFIG_RAM_DWIDTH (DW),
    .DB_FIFO_DEPTH     (8)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .s_db_qpn            (s_db_qpn),
    .s_db_valid          (s_db_valid),
    .s_db_ready          (s_db_ready),
    .tx_config_ram_ren   (ren),
    .tx_config_ram_raddr (raddr),
    .tx_config_ram_rdata (rdata),
    .m_wqe_data          (m_wqe_data),
    .m_wqe_qpn           (m_wqe_qpn),
    .m_wqe_opcode        (m_wqe_opcode),
    .m_wqe_len           (m_wqe_len),
    .m_wqe_valid         (m_wqe_valid),
    .m_wqe_ready         (m_wqe_ready),
    .stat_wqe_cnt        (stat_wqe_cnt),
    .stat_inv_cnt        (stat_inv_cnt)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [16];
  logic          ram_vld [16];
  logic [3:0]    ram_opc [16];
  logic [31:0]   ram_len [16];

  always @(posedge clk) begin
    if (ren)
      rdata <= ram[raddr];
  end

  typedef struct {
    logic [AW-1:0] qpn;
    logic [DW-1:0] data;
    logic [3:0]    opc;
    logic [31:0]   len;
  } exp_t;

  typedef struct {
    logic [AW-1:0] qpn;
    logic          vld;
    logic [3:0]    opc;
    logic [31:0]   len;
    logic [31:0]   exp_wqe;
    logic [15:0]   exp_inv;
  } vec_t;

  exp_t      sb[$];
  longint    hs_t[$];
  int        checks = 0;
  int        errors = 0;
  int        seen_valid = 0;
  vec_t      vt[6];

  function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void fail(string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", name);
  endfunction

  task automatic set_entry(int q, logic vld, logic [3:0] opc, logic [31:0] len);
    logic [DW-1:0] e;
    e = '0;
    e[DW-1 -: 32] = $urandom;
    e[200 +: 32]  = $urandom;
    e[63:32] = len;
    e[7:4]   = opc;
    e[3:1]   = 3'($urandom);
    e[0]     = vld;
    ram[q]     = e;
    ram_vld[q] = vld;
    ram_opc[q] = opc;
    ram_len[q] = len;
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send_db(int q);
    int n;
    exp_t e;
    s_db_valid = 1'b1;
    s_db_qpn   = AW'(q);
    n = 0;
    while (!s_db_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      fail("db_accept");
    end else if (ram_vld[q]) begin
      e.qpn  = AW'(q);
      e.data = ram[q];
      e.opc  = ram_opc[q];
      e.len  = ram_len[q];
      sb.push_back(e);
    end
    @(negedge clk);
    s_db_valid = 1'b0;
  endtask

  task automatic wait_drain(string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || m_wqe_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500)
      fail(name);
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("ready_in_rst", 512'(s_db_ready), 512'(0));
    @(negedge clk);
    sb.delete();
    hs_t.delete();
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Snapshot taken 1 time unit after each negedge so inputs are settled.
  task automatic monitor();
    logic          held;
    logic [DW-1:0] hd;
    logic [AW-1:0] hq;
    logic [3:0]    ho;
    logic [31:0]   hl;
    exp_t          e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        held = 1'b0;
      end else begin
        if (m_wqe_valid)
          seen_valid++;
        if (held) begin
          chk("hold_valid", 512'(m_wqe_valid), 512'(1));
          chk("hold_data", m_wqe_data, hd);
          chk("hold_qpn", 512'(m_wqe_qpn), 512'(hq));
          chk("hold_opc", 512'(m_wqe_opcode), 512'(ho));
          chk("hold_len", 512'(m_wqe_len), 512'(hl));
        end
        if (m_wqe_valid && m_wqe_ready) begin
          hs_t.push_back($time);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_wqe: got qpn %0d expected none", m_wqe_qpn);
          end else begin
            e = sb.pop_front();
            chk("wqe_qpn", 512'(m_wqe_qpn), 512'(e.qpn));
            chk("wqe_data", m_wqe_data, e.data);
            chk("wqe_opc", 512'(m_wqe_opcode), 512'(e.opc));
            chk("wqe_len", 512'(m_wqe_len), 512'(e.len));
          end
          held = 1'b0;
        end else if (m_wqe_valid) begin
          held = 1'b1;
          hd = m_wqe_data;
          hq = m_wqe_qpn;
          ho = m_wqe_opcode;
          hl = m_wqe_len;
        end else begin
          held = 1'b0;
        end
      end
    end
  endtask

  initial begin
    int n;
    int base;
    vt[0] = '{4'd5,  1'b0, 4'h0, 32'h0,        32'd1, 16'd1};
    vt[1] = '{4'd0,  1'b1, 4'hF, 32'hFFFFFFFF, 32'd2, 16'd1};
    vt[2] = '{4'd15, 1'b1, 4'h0, 32'h0,        32'd3, 16'd1};
    vt[3] = '{4'd7,  1'b0, 4'h9, 32'h1234,     32'd3, 16'd2};
    vt[4] = '{4'd9,  1'b1, 4'h5, 32'hDEADBEEF, 32'd4, 16'd2};
    vt[5] = '{4'd3,  1'b1, 4'h1, 32'h1,        32'd5, 16'd2};
    for (int i = 0; i < 16; i++)
      set_entry(i, 1'b0, 4'h0, 32'h0);

    fork
      monitor();
    join_none

    do_reset();
    chk("rst_ready", 512'(s_db_ready), 512'(1));
    chk("rst_valid", 512'(m_wqe_valid), 512'(0));
    chk("rst_ren", 512'(ren), 512'(0));
    chk("rst_data", m_wqe_data, 512'(0));
    chk("rst_len", 512'(m_wqe_len), 512'(0));
    chk("rst_wqe_cnt", 512'(stat_wqe_cnt), 512'(0));
    chk("rst_inv_cnt", 512'(stat_inv_cnt), 512'(0));

    // Single valid WQE with exact latency.
    m_wqe_ready = 1'b1;
    set_entry(3, 1'b1, 4'h2, 32'h100);
    fork
      send_db(3);
    join_none
    @(negedge clk);
    @(negedge clk);
    chk("lat_ren", 512'(ren), 512'(1));
    chk("lat_raddr", 512'(raddr), 512'(3));
    @(negedge clk);
    chk("lat_t3_valid", 512'(m_wqe_valid), 512'(0));
    @(negedge clk);
    chk("lat_t4_valid", 512'(m_wqe_valid), 512'(1));
    chk("lat_len", 512'(m_wqe_len), 512'(32'h100));
    chk("lat_opc", 512'(m_wqe_opcode), 512'(4'h2));
    repeat (3) @(negedge clk);
    chk("single_wqe_cnt", 512'(stat_wqe_cnt), 512'(1));

    // Vector table; cumulative counter expectations.
    for (int i = 0; i < 6; i++) begin
      set_entry(int'(vt[i].qpn), vt[i].vld, vt[i].opc, vt[i].len);
      send_db(int'(vt[i].qpn));
      wait_drain("vec_drain");
      chk("vec_wqe_cnt", 512'(stat_wqe_cnt), 512'(vt[i].exp_wqe));
      chk("vec_inv_cnt", 512'(stat_inv_cnt), 512'(vt[i].exp_inv));
      chk("vec_idle_valid", 512'(m_wqe_valid), 512'(0));
    end

    // Backpressure and fill: 1 in flight plus 8 queued.
    base = int'(stat_wqe_cnt);
    m_wqe_ready = 1'b0;
    for (int i = 0; i < 9; i++)
      set_entry(i, 1'b1, 4'(i + 3), 32'h1000 + 32'(i));
    for (int i = 0; i < 9; i++)
      send_db(i);
    repeat (5) @(negedge clk);
    chk("full_ready", 512'(s_db_ready), 512'(0));
    chk("bp_valid", 512'(m_wqe_valid), 512'(1));
    chk("bp_qpn", 512'(m_wqe_qpn), 512'(0));
    m_wqe_ready = 1'b1;
    wait_drain("bp_drain");
    chk("bp_wqe_cnt", 512'(stat_wqe_cnt), 512'(base + 9));
    chk("bp_ready_back", 512'(s_db_ready), 512'(1));

    // Back-to-back: outputs 4 cycles apart.
    base = int'(stat_wqe_cnt);
    hs_t.delete();
    for (int i = 0; i < 4; i++)
      send_db(i);
    wait_drain("b2b_drain");
    chk("b2b_count", 512'(hs_t.size()), 512'(4));
    chk("b2b_wqe_cnt", 512'(stat_wqe_cnt), 512'(base + 4));
    for (int i = 1; i < hs_t.size(); i++)
      chk("b2b_spacing", 512'(hs_t[i] - hs_t[i-1]), 512'(40));

    // Reset while a WQE is being offered.
    m_wqe_ready = 1'b0;
    set_entry(1, 1'b1, 4'h7, 32'h77);
    set_entry(2, 1'b1, 4'h8, 32'h88);
    set_entry(4, 1'b1, 4'h9, 32'h99);
    send_db(1);
    send_db(2);
    send_db(4);
    n = 0;
    while (!m_wqe_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50)
      fail("rst_mid_wait_valid");
    do_reset();
    seen_valid = 0;
    m_wqe_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_mid_no_out", 512'(seen_valid), 512'(0));
    chk("rst_mid_wqe_cnt", 512'(stat_wqe_cnt), 512'(0));
    chk("rst_mid_ready", 512'(s_db_ready), 512'(1));

    // Saturation of the invalid counter.
    force dut.inv_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.inv_cnt_q;
    set_entry(5, 1'b0, 4'h0, 32'h0);
    send_db(5);
    wait_drain("sat_drain1");
    chk("sat_first", 512'(stat_inv_cnt), 512'(16'hFFFF));
    send_db(5);
    send_db(5);
    wait_drain("sat_drain2");
    chk("sat_hold", 512'(stat_inv_cnt), 512'(16'hFFFF));
    chk("sat_no_out", 512'(stat_wqe_cnt), 512'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
